// File: rtl/lane_serializer_pkg.sv
// Shared definitions for the lane serializer: derived sizing and FSM encoding.
package lane_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Lanes needed to cover a word; the word is zero-extended up to a whole lane count.
  function automatic int calc_num_lanes(input int data_w, input int lane_w);
    return (data_w + lane_w - 1) / lane_w;
  endfunction

  // Counter width able to hold every value from 0 through num_lanes.
  function automatic int calc_cnt_w(input int num_lanes);
    return $clog2(num_lanes + 1);
  endfunction

endpackage

// File: rtl/lane_serializer_mux.sv
// Combinational lane select: picks one LANE_W slice of a packed multi-lane vector.
module lane_serializer_mux #(
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 3,
  parameter int CNT_W     = 2
) (
  input  logic [NUM_LANES*LANE_W-1:0] vec,
  input  logic [CNT_W-1:0]            idx,
  output logic [LANE_W-1:0]           lane
);

  // Index decode; out-of-range indices yield zero.
  always_comb begin
    lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx == CNT_W'(i)) lane = vec[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// Handshaked word-to-lane serializer: one DATA_W word out as N LANE_W lanes,
// LSB-lane-first or MSB-lane-first, with zero-bubble back-to-back words.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int LANE_W = 8,
  localparam int NUM_LANES = calc_num_lanes(DATA_W, LANE_W),
  localparam int CNT_W     = calc_cnt_w(NUM_LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_lanes,
  input  logic              in_msb_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_idx,
  output logic              out_last
);

  localparam int TOT_W = NUM_LANES * LANE_W;

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   word_q;
  logic               dir_q;
  logic [CNT_W-1:0]   rem_q;
  logic [CNT_W-1:0]   idx_q;
  logic [LANE_W-1:0]  data_q;
  logic               valid_q;
  logic               last_q;

  logic               accept;
  logic               beat;
  logic [TOT_W-1:0]   in_ext;
  logic [CNT_W-1:0]   n_eff;
  logic [CNT_W-1:0]   first_idx;
  logic [CNT_W-1:0]   next_idx;
  logic [CNT_W-1:0]   rem_m1;
  logic [TOT_W-1:0]   mux_vec;
  logic [CNT_W-1:0]   mux_idx;
  logic [LANE_W-1:0]  mux_lane;

  assign beat     = valid_q & out_ready;
  assign in_ready = (state_q == ST_IDLE) | (beat & last_q);
  assign accept   = in_valid & in_ready;

  assign in_ext    = TOT_W'(in_data);
  assign n_eff     = ((in_lanes == '0) || (in_lanes > CNT_W'(NUM_LANES))) ? CNT_W'(NUM_LANES) : in_lanes;
  assign first_idx = in_msb_first ? (n_eff - CNT_W'(1)) : '0;
  assign next_idx  = dir_q ? (idx_q - CNT_W'(1)) : (idx_q + CNT_W'(1));
  assign rem_m1    = rem_q - CNT_W'(1);

  // A newly accepted word loads its first lane through the same mux used for stepping.
  assign mux_vec = accept ? in_ext : word_q;
  assign mux_idx = accept ? first_idx : next_idx;

  lane_serializer_mux #(
    .LANE_W    (LANE_W),
    .NUM_LANES (NUM_LANES),
    .CNT_W     (CNT_W)
  ) u_mux (
    .vec  (mux_vec),
    .idx  (mux_idx),
    .lane (mux_lane)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: stay in SEND while words keep arriving on the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (beat && last_q && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Word capture and registered lane output; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (accept) begin
      word_q  <= in_ext;
      dir_q   <= in_msb_first;
      rem_q   <= n_eff;
      idx_q   <= first_idx;
      data_q  <= mux_lane;
      valid_q <= 1'b1;
      last_q  <= (n_eff == CNT_W'(1));
    end else if (beat) begin
      if (!last_q) begin
        idx_q  <= next_idx;
        rem_q  <= rem_m1;
        data_q <= mux_lane;
        last_q <= (rem_m1 == CNT_W'(1));
      end else begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: table of words with expected lane sequences feeding a
// scoreboard, plus hand-written stall, back-to-back and mid-word reset sequences.
module tb_lane_serializer;

  localparam int DATA_W = 18;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CNT_W-1:0]  in_lanes = '0;
  logic              in_msb_first = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LANE_W-1:0] out_data;
  logic [CNT_W-1:0]  out_idx;
  logic              out_last;

  lane_serializer #(.DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_lanes     (in_lanes),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  lanes;
    logic              msb;
    int                n;
    logic [2:0][7:0]   d;    // d[0] is the first lane emitted
    logic [2:0][1:0]   idx;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  vec_t vt[10];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Scoreboard: every accepted lane is compared against the next expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_lane", {30'd0, out_idx}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lane_data", {24'd0, out_data}, {24'd0, e.d});
        check("lane_idx",  {30'd0, out_idx},  {30'd0, e.idx});
        check("lane_last", {31'd0, out_last}, {31'd0, e.last});
        check("in_ready_on_beat", {31'd0, in_ready}, {31'd0, e.last});
      end
    end
  end

  task automatic send_word(input int k);
    bit ok;
    ok = 0;
    in_valid     = 1'b1;
    in_data      = vt[k].data;
    in_lanes     = vt[k].lanes;
    in_msb_first = vt[k].msb;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int j = 0; j < vt[k].n; j++) begin
          exp_t e;
          e.d    = vt[k].d[j];
          e.idx  = vt[k].idx[j];
          e.last = (j == vt[k].n - 1);
          sb.push_back(e);
        end
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    check("drain", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"},  {24'd0, out_data},  32'd0);
    check({tag, "_out_idx"},   {30'd0, out_idx},   32'd0);
    check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    vt[0] = '{18'h2A5C3, 2'd3, 1'b0, 3, {8'h02, 8'hA5, 8'hC3}, {2'd2, 2'd1, 2'd0}};
    vt[1] = '{18'h2A5C3, 2'd2, 1'b1, 2, {8'h00, 8'hC3, 8'hA5}, {2'd0, 2'd0, 2'd1}};
    vt[2] = '{18'h2A5C3, 2'd0, 1'b0, 3, {8'h02, 8'hA5, 8'hC3}, {2'd2, 2'd1, 2'd0}};
    vt[3] = '{18'h10FF1, 2'd3, 1'b1, 3, {8'hF1, 8'h0F, 8'h01}, {2'd0, 2'd1, 2'd2}};
    vt[4] = '{18'h3FFFF, 2'd1, 1'b0, 1, {8'h00, 8'h00, 8'hFF}, {2'd0, 2'd0, 2'd0}};
    vt[5] = '{18'h3FFFF, 2'd1, 1'b1, 1, {8'h00, 8'h00, 8'hFF}, {2'd0, 2'd0, 2'd0}};
    vt[6] = '{18'h3FFFF, 2'd2, 1'b0, 2, {8'h00, 8'hFF, 8'hFF}, {2'd0, 2'd1, 2'd0}};
    vt[7] = '{18'h3FFFF, 2'd3, 1'b1, 3, {8'hFF, 8'hFF, 8'h03}, {2'd0, 2'd1, 2'd2}};
    vt[8] = '{18'h12345, 2'd0, 1'b1, 3, {8'h45, 8'h23, 8'h01}, {2'd0, 2'd1, 2'd2}};
    vt[9] = '{18'h10FF1, 2'd3, 1'b0, 3, {8'h01, 8'h0F, 8'hF1}, {2'd2, 2'd1, 2'd0}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Table-driven words, one at a time, downstream always ready
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send_word(k);
      wait_drain();
      @(posedge clk);
      #1;
    end

    // Stall after first lane: outputs hold, no new word accepted
    out_ready = 1'b0;
    send_word(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data",  {24'd0, out_data},  32'hC3);
      check("stall_idx",   {30'd0, out_idx},   32'd0);
      check("stall_last",  {31'd0, out_last},  32'd0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back words: six lanes with no gap in out_valid
    @(posedge clk);
    #1;
    fork
      begin
        send_word(0);
        send_word(9);
      end
      begin
        bit seen;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1;
            break;
          end
        end
        check("b2b_start", {31'd0, seen}, 32'd1);
        for (int i = 1; i < 6; i++) begin
          @(negedge clk);
          check("b2b_no_gap", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        check("b2b_idle_after", {31'd0, out_valid}, 32'd0);
      end
    join
    wait_drain();

    // Reset mid-word after lane A5
    @(posedge clk);
    #1;
    send_word(0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_word(9);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
